// File: rtl/axis_stream_distributor.sv
// -----------------------------------------------------------------------------
// axis_stream_distributor
//
// Purpose:
//   One-to-two AXI-Stream packet distributor. Whole packets from a single
//   upstream stream are steered to downstream port 1 or port 2, either by the
//   tdest bit of the first beat (RR_MODE = 0) or by per-packet round-robin
//   alternation (RR_MODE = 1). The route is locked from the first beat of a
//   packet until its tlast beat. A two-entry buffer (main + skid) gives
//   1 beat/cycle throughput while s_axis_tready comes straight from a flop.
//
// Ports:
//   axis_clk, resetn           clock (rising edge), asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast/tdest   upstream slave interface
//   m_axis_tvalid1/tready1/tdata1/tlast1     downstream port 1 (route tag 0)
//   m_axis_tvalid2/tready2/tdata2/tlast2     downstream port 2 (route tag 1)
// -----------------------------------------------------------------------------
module axis_stream_distributor #(
    parameter int DATA_WIDTH = 8,
    parameter int RR_MODE    = 0
) (
    input  logic                  axis_clk,
    input  logic                  resetn,

    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tdest,

    output logic                  m_axis_tvalid1,
    input  logic                  m_axis_tready1,
    output logic [DATA_WIDTH-1:0] m_axis_tdata1,
    output logic                  m_axis_tlast1,

    output logic                  m_axis_tvalid2,
    input  logic                  m_axis_tready2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata2,
    output logic                  m_axis_tlast2
);

    typedef enum logic {
        S_HEAD = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_route_q;
    logic                  r_rr_ptr;
    logic                  r_s_ready;

    // Main entry: the only one presented downstream. Tag 0 = port 1, 1 = port 2.
    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_last;
    logic                  r_main_tag;

    // Skid entry: catches the beat accepted while main is held.
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  r_skid_tag;

    logic                  w_accept;
    logic                  w_route;
    logic                  w_drain;
    logic                  w_skid_valid_next;

    assign w_accept = s_axis_tvalid & r_s_ready;

    // First beat picks the route; body beats reuse the latched one.
    assign w_route = (r_state == S_HEAD) ? ((RR_MODE != 0) ? r_rr_ptr : s_axis_tdest)
                                         : r_route_q;

    assign w_drain = r_main_valid & (r_main_tag ? m_axis_tready2 : m_axis_tready1);

    // When main drains the skid always empties: either it moves into main, or
    // it was already empty (an accept can only happen with the skid empty, and
    // then the new beat goes straight into main).
    assign w_skid_valid_next = ~w_drain & (r_skid_valid | (w_accept & r_main_valid));

    always_ff @(posedge axis_clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_HEAD;
            r_route_q    <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_s_ready    <= 1'b0;
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_last  <= 1'b0;
            r_main_tag   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_tag   <= 1'b0;
        end else begin
            // Route FSM and round-robin pointer
            if (w_accept) begin
                if (r_state == S_HEAD) begin
                    r_route_q <= w_route;
                    r_state   <= s_axis_tlast ? S_HEAD : S_BODY;
                end else if (s_axis_tlast) begin
                    r_state <= S_HEAD;
                end
                if (s_axis_tlast) begin
                    r_rr_ptr <= ~r_rr_ptr;
                end
            end

            // Main entry
            if (w_drain) begin
                if (r_skid_valid) begin
                    r_main_data <= r_skid_data;
                    r_main_last <= r_skid_last;
                    r_main_tag  <= r_skid_tag;
                end else if (w_accept) begin
                    r_main_data <= s_axis_tdata;
                    r_main_last <= s_axis_tlast;
                    r_main_tag  <= w_route;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept && !r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= s_axis_tdata;
                r_main_last  <= s_axis_tlast;
                r_main_tag   <= w_route;
            end

            // Skid entry
            if (!w_drain && w_accept && r_main_valid) begin
                r_skid_data <= s_axis_tdata;
                r_skid_last <= s_axis_tlast;
                r_skid_tag  <= w_route;
            end
            r_skid_valid <= w_skid_valid_next;

            // Ready looks at the next skid state so a full skid is never overrun.
            r_s_ready <= ~w_skid_valid_next;
        end
    end

    assign s_axis_tready  = r_s_ready;

    assign m_axis_tvalid1 = r_main_valid & ~r_main_tag;
    assign m_axis_tdata1  = m_axis_tvalid1 ? r_main_data : '0;
    assign m_axis_tlast1  = m_axis_tvalid1 & r_main_last;

    assign m_axis_tvalid2 = r_main_valid & r_main_tag;
    assign m_axis_tdata2  = m_axis_tvalid2 ? r_main_data : '0;
    assign m_axis_tlast2  = m_axis_tvalid2 & r_main_last;

endmodule
